// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile
//   AXI-lite slave register file with NUM_REGS registers of DATA_WIDTH bits.
//   Write address and write data channels are independent and may complete
//   in either order. Read-only registers (RO_MASK) reflect hw_in. Out-of-range
//   or read-only writes return an error response and change nothing.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   waddr/wavalid/waready    write address channel
//   wdata/wvalid/wready      write data channel
//   wresp/bvalid/bready      write response channel (wresp: 0=OK, 1=error)
//   raddr/arvalid/arready    read address channel
//   rdata/rvalid/rready      read data channel
//   hw_in                    status values for read-only registers
//   reg_out                  register contents (RO slots show hw_in)
//   wr_pulse                 one-cycle strobe per register on a successful write
module axi_lite_regfile #(
  parameter int unsigned                         ADDR_WIDTH = 5,
  parameter int unsigned                         DATA_WIDTH = 32,
  parameter int unsigned                         NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]                 RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]      RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic                           wavalid,
  output logic                           waready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic                           wvalid,
  output logic                           wready,
  output logic                           wresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          raddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rvalid,
  input  logic                           rready,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

  w_state_e                w_state_q, w_state_d;
  r_state_e                r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    wresp_q, wresp_d;
  logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

  logic                    aw_hs, w_hs;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [DATA_WIDTH-1:0]   c_data;
  logic [IDX_W-1:0]        c_idx;
  logic                    c_ok;
  logic [DEPTH-1:0]        ro_pad;
  logic [IDX_W-1:0]        r_idx;
  logic [DEPTH*DATA_WIDTH-1:0] reg_pad;
  logic                    unused_bits;

  // Address low bits are byte offsets within a word; RW slots of hw_in are
  // not consumed.
  assign unused_bits = ^{waddr[1:0], raddr[1:0], hw_in};

  // Mask and register view padded to the full decoded address space so any
  // word index can be looked up without a separate bounds check.
  always_comb begin
    ro_pad = '0;
    ro_pad[NUM_REGS-1:0] = RO_MASK;
  end

  always_comb begin
    reg_pad = '0;
    reg_pad[NUM_REGS*DATA_WIDTH-1:0] = reg_out;
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] =
        RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
    end
  end

  // ---------------------------------------------------------------- write
  assign waready  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_D);
  assign wready   = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_A);
  assign bvalid   = (w_state_q == W_RESP);
  assign wresp    = wresp_q;
  assign wr_pulse = wr_pulse_q;

  assign aw_hs = wavalid && waready;
  assign w_hs  = wvalid && wready;

  // The commit address/data come from the bus for whichever half completes
  // on this edge and from the capture register for the half that came first.
  always_comb begin
    w_state_d  = w_state_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wresp_d    = wresp_q;
    commit     = 1'b0;
    c_addr     = waddr_q;
    c_data     = wdata_q;
    wr_pulse_d = '0;

    if (aw_hs) waddr_d = waddr;
    if (w_hs)  wdata_d = wdata;

    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_state_d = W_RESP;
          commit    = 1'b1;
          c_addr    = waddr;
          c_data    = wdata;
        end else if (aw_hs) begin
          w_state_d = W_HAVE_A;
        end else if (w_hs) begin
          w_state_d = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        if (w_hs) begin
          w_state_d = W_RESP;
          commit    = 1'b1;
          c_addr    = waddr_q;
          c_data    = wdata;
        end
      end
      W_HAVE_D: begin
        if (aw_hs) begin
          w_state_d = W_RESP;
          commit    = 1'b1;
          c_addr    = waddr;
          c_data    = wdata_q;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          wresp_d   = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    c_idx = c_addr[ADDR_WIDTH-1:2];
    c_ok  = (32'(c_idx) < NUM_REGS) && !ro_pad[c_idx];

    if (commit) wresp_d = !c_ok;

    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      wr_pulse_d[i] = commit && c_ok && (32'(c_idx) == i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wresp_q    <= 1'b0;
      wr_pulse_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wresp_q    <= wresp_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // The write strobe doubles as the per-register write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_pulse_d[i]) regs_q[i] <= c_data;
      end
    end
  end

  // ----------------------------------------------------------------- read
  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_RESP);
  assign rdata   = rdata_q;
  assign r_idx   = raddr[ADDR_WIDTH-1:2];

  // rdata samples the pre-edge register view, so a read accepted on the same
  // edge as a write commit returns the old value.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          r_state_d = R_RESP;
          rdata_d   = reg_pad[r_idx*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      R_RESP: begin
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb_axi_lite_regfile
//   Directed bench for axi_lite_regfile. Two instances share all inputs:
//   dut8 (8 regs, reg 7 read-only, non-zero reset values) and dut6 (6 regs,
//   all RW). Expected responses are pushed to queues when stimulus is driven
//   and popped when the DUTs respond.
module tb_axi_lite_regfile;

  localparam logic [255:0] RV8 = {32'h700, 32'h600, 32'h500, 32'h400,
                                  32'h300, 32'h200, 32'h100, 32'h000};

  logic         clk;
  logic         rst;
  logic [4:0]   waddr;
  logic         wavalid;
  logic [31:0]  wdata;
  logic         wvalid;
  logic         bready;
  logic [4:0]   raddr;
  logic         arvalid;
  logic         rready;
  logic [255:0] hw_in;

  logic         waready8, wready8, wresp8, bvalid8, arready8, rvalid8;
  logic [31:0]  rdata8;
  logic [255:0] reg_out8;
  logic [7:0]   wr_pulse8;

  logic         waready6, wready6, wresp6, bvalid6, arready6, rvalid6;
  logic [31:0]  rdata6;
  logic [191:0] reg_out6;
  logic [5:0]   wr_pulse6;

  axi_lite_regfile #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_REGS(8),
    .RO_MASK(8'h80), .RESET_VAL(RV8)
  ) dut8 (
    .clk(clk), .rst(rst),
    .waddr(waddr), .wavalid(wavalid), .waready(waready8),
    .wdata(wdata), .wvalid(wvalid), .wready(wready8),
    .wresp(wresp8), .bvalid(bvalid8), .bready(bready),
    .raddr(raddr), .arvalid(arvalid), .arready(arready8),
    .rdata(rdata8), .rvalid(rvalid8), .rready(rready),
    .hw_in(hw_in), .reg_out(reg_out8), .wr_pulse(wr_pulse8)
  );

  axi_lite_regfile #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_REGS(6)
  ) dut6 (
    .clk(clk), .rst(rst),
    .waddr(waddr), .wavalid(wavalid), .waready(waready6),
    .wdata(wdata), .wvalid(wvalid), .wready(wready6),
    .wresp(wresp6), .bvalid(bvalid6), .bready(bready),
    .raddr(raddr), .arvalid(arvalid), .arready(arready6),
    .rdata(rdata6), .rvalid(rvalid6), .rready(rready),
    .hw_in(hw_in[191:0]), .reg_out(reg_out6), .wr_pulse(wr_pulse6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       err8;
    logic       err6;
    logic [7:0] p8;
    logic [5:0] p6;
  } wexp_t;

  typedef struct packed {
    logic [31:0] d8;
    logic [31:0] d6;
  } rexp_t;

  wexp_t       wq[$];
  rexp_t       rq[$];
  logic [31:0] m8 [8];
  logic [31:0] m6 [6];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 8; i++) m8[i] = 32'(i) * 32'h100;
    for (int i = 0; i < 6; i++) m6[i] = '0;
  endtask

  function automatic logic [255:0] exp_out8();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = (i == 7) ? hw_in[i*32 +: 32] : m8[i];
    return v;
  endfunction

  function automatic logic [255:0] exp_out6();
    logic [255:0] v = '0;
    for (int i = 0; i < 6; i++) v[i*32 +: 32] = m6[i];
    return v;
  endfunction

  task automatic push_write(input logic [4:0] a, input logic [31:0] d);
    wexp_t       e;
    int unsigned idx;
    idx    = 32'(a[4:2]);
    e.err8 = (idx == 7);
    e.err6 = (idx >= 6);
    e.p8   = '0;
    e.p6   = '0;
    if (!e.err8) begin e.p8[idx] = 1'b1; m8[idx] = d; end
    if (!e.err6) begin e.p6[idx] = 1'b1; m6[idx] = d; end
    wq.push_back(e);
  endtask

  task automatic push_read(input logic [4:0] a);
    rexp_t       r;
    int unsigned idx;
    idx  = 32'(a[4:2]);
    r.d8 = (idx == 7) ? hw_in[idx*32 +: 32] : m8[idx];
    r.d6 = (idx < 6) ? m6[idx] : 32'h0;
    rq.push_back(r);
  endtask

  task automatic collect_write(input int hold);
    int    n = 0;
    wexp_t e;
    while (!(bvalid8 && bvalid6) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b_latency", 256'(n), 256'(0));
    e = wq.pop_front();
    chk("wresp8", 256'(wresp8), 256'(e.err8));
    chk("wresp6", 256'(wresp6), 256'(e.err6));
    chk("wr_pulse8", 256'(wr_pulse8), 256'(e.p8));
    chk("wr_pulse6", 256'(wr_pulse6), 256'(e.p6));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("b_hold",
          256'({bvalid8, bvalid6, wresp8, wresp6, waready8, waready6, wready8, wready6,
                wr_pulse8, wr_pulse6}),
          256'({2'b11, e.err8, e.err6, 4'b0000, 14'b0}));
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("b_done", 256'({bvalid8, bvalid6, wr_pulse8, wr_pulse6, waready8, wready8}),
        256'({16'b0, 2'b11}));
  endtask

  task automatic collect_read();
    int    n = 0;
    rexp_t r;
    while (!(rvalid8 && rvalid6) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("r_latency", 256'(n), 256'(0));
    r = rq.pop_front();
    chk("rdata8", 256'(rdata8), 256'(r.d8));
    chk("rdata6", 256'(rdata6), 256'(r.d6));
    chk("r_arready_busy", 256'({arready8, arready6}), 256'(2'b00));
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("r_done", 256'({rvalid8, rvalid6, arready8, arready6}), 256'(4'b0011));
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input int hold);
    waddr   = a;
    wdata   = d;
    wavalid = 1'b1;
    wvalid  = 1'b1;
    push_write(a, d);
    @(negedge clk);
    wavalid = 1'b0;
    wvalid  = 1'b0;
    waddr   = 5'h1F;
    wdata   = 32'hFFFF_FFFF;
    collect_write(hold);
  endtask

  task automatic do_read(input logic [4:0] a);
    raddr   = a;
    arvalid = 1'b1;
    push_read(a);
    @(negedge clk);
    arvalid = 1'b0;
    raddr   = 5'h1F;
    collect_read();
  endtask

  initial begin
    rst     = 1'b1;
    waddr   = '0;
    wavalid = 1'b0;
    wdata   = '0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    raddr   = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    for (int i = 0; i < 8; i++) hw_in[i*32 +: 32] = 32'h5A5A_0000 | 32'(i);
    hw_in[7*32 +: 32] = 32'hCAFE_0001;
    reset_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_reg_out8", reg_out8, exp_out8());
    chk("rst_reg_out6", 256'(reg_out6), exp_out6());
    chk("rst_hs8", 256'({waready8, wready8, arready8, bvalid8, rvalid8, wresp8}), 256'(6'b111000));
    chk("rst_hs6", 256'({waready6, wready6, arready6, bvalid6, rvalid6, wresp6}), 256'(6'b111000));
    chk("rst_misc", 256'({rdata8, rdata6, wr_pulse8, wr_pulse6}), 256'(0));

    // Address and data in the same cycle
    do_write(5'h04, 32'hDEAD_BEEF, 0);
    do_read(5'h04);

    // Data before address, captured data survives bus changes
    wdata  = 32'h1234_5678;
    wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    wdata  = 32'hFFFF_FFFF;
    chk("dfirst_c1", 256'({wready8, waready8, bvalid8}), 256'(3'b010));
    @(negedge clk);
    chk("dfirst_c2", 256'({wready8, waready8, bvalid8}), 256'(3'b010));
    chk("dfirst_c3", 256'({wready8, wready6, bvalid6}), 256'(3'b000));
    waddr   = 5'h08;
    wavalid = 1'b1;
    push_write(5'h08, 32'h1234_5678);
    @(negedge clk);
    wavalid = 1'b0;
    waddr   = 5'h1F;
    collect_write(0);
    chk("dfirst_reg8", reg_out8, exp_out8());
    chk("dfirst_reg6", 256'(reg_out6), exp_out6());

    // Read-only register: error, no pulse, value from hw_in
    do_write(5'h1C, 32'h0BAD_F00D, 0);
    chk("ro_reg8", reg_out8, exp_out8());
    do_read(5'h1C);

    // Index 6: valid in dut8, out of range in dut6; response held under backpressure
    do_write(5'h18, 32'h6666_0018, 5);
    chk("oor_reg6", 256'(reg_out6), exp_out6());
    chk("oor_reg8", reg_out8, exp_out8());
    do_read(5'h18);
    do_read(5'h14);

    // Read accepted on the same edge as a write commit returns the old value
    waddr   = 5'h00;
    wdata   = 32'hA5A5_A5A5;
    wavalid = 1'b1;
    wvalid  = 1'b1;
    raddr   = 5'h00;
    arvalid = 1'b1;
    push_read(5'h00);
    push_write(5'h00, 32'hA5A5_A5A5);
    @(negedge clk);
    wavalid = 1'b0;
    wvalid  = 1'b0;
    arvalid = 1'b0;
    collect_write(0);
    collect_read();
    chk("same_cycle_reg8", reg_out8, exp_out8());
    do_read(5'h00);

    // Reset while holding an address and an outstanding read
    waddr   = 5'h0C;
    wavalid = 1'b1;
    raddr   = 5'h04;
    arvalid = 1'b1;
    @(negedge clk);
    wavalid = 1'b0;
    arvalid = 1'b0;
    chk("have_a_state", 256'({waready8, wready8, rvalid8, bvalid8}), 256'(4'b0110));
    #2 rst = 1'b1;
    #1;
    reset_model();
    chk("arst_hs8", 256'({waready8, wready8, arready8, bvalid8, rvalid8, wresp8}), 256'(6'b111000));
    chk("arst_hs6", 256'({waready6, wready6, arready6, bvalid6, rvalid6, wresp6}), 256'(6'b111000));
    chk("arst_misc", 256'({rdata8, rdata6, wr_pulse8, wr_pulse6}), 256'(0));
    chk("arst_reg8", reg_out8, exp_out8());
    chk("arst_reg6", 256'(reg_out6), exp_out6());
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_resp_after_rst",
          256'({bvalid8, bvalid6, rvalid8, rvalid6, wr_pulse8, wr_pulse6}), 256'(0));
    end

    do_write(5'h10, 32'h1357_9BDF, 0);
    chk("post_rst_reg8", reg_out8, exp_out8());
    do_read(5'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
